// File: rtl/synth_audio_pkg.sv
// synth_audio_pkg: shared types and constants for the synth audio output path.
// Frame geometry, FSM states and the stereo sample pair bundle.
package synth_audio_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int SLOT_W       = 32;
    localparam int MCLK_PER_SCK = 4;
    localparam int FRAME_MCLK   = 256;
    localparam int FCNT_W       = $clog2(FRAME_MCLK);
    localparam int BIT_W        = $clog2(2 * SLOT_W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } pair_t;

    // Data bit for frame bit index b: MSB at slot bit 1, zero-padded slot.
    function automatic logic slot_bit(input pair_t p, input logic [BIT_W-1:0] b);
        logic [SAMPLE_W-1:0] ch;
        logic [4:0]          s;
        logic [3:0]          idx;
        ch  = b[BIT_W-1] ? p.right : p.left;
        s   = b[4:0];
        idx = 4'(5'(SAMPLE_W) - s);
        if (s >= 5'd1 && s <= 5'(SAMPLE_W)) begin
            return ch[idx];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/i2s_frame_sequencer_clk_gen.sv
// i2s_clk_gen: mclk prescaler and 256-mclk frame counter.
// Strobes mark the clk in which sck falls and in which the frame wraps.
module i2s_clk_gen
    import synth_audio_pkg::*;
#(
    parameter int MCLK_HALF = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             mclk,
    output logic             sck,
    output logic             lrck,
    output logic [BIT_W-1:0] bit_next,
    output logic             wrap,
    output logic             sck_fall
);

    localparam int DIV_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_HALF - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [FCNT_W-1:0] fcnt;
    logic              step;
    logic              fall;

    assign step     = run && (div_cnt == DIV_LAST);
    assign fall     = step && mclk;
    assign wrap     = fall && (fcnt == '1);
    assign sck_fall = fall && (fcnt[1:0] == 2'b11);
    assign sck      = fcnt[1];
    assign lrck     = fcnt[FCNT_W-1];
    assign bit_next = fcnt[FCNT_W-1:2] + BIT_W'(1);

    // Prescaler, mclk toggle and frame counter; all held at zero when stopped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            mclk    <= 1'b0;
            fcnt    <= '0;
        end else if (run) begin
            div_cnt <= step ? '0 : div_cnt + DIV_W'(1);
            if (step) mclk <= ~mclk;
            if (fall) fcnt <= fcnt + 1'b1;
        end else begin
            div_cnt <= '0;
            mclk    <= 1'b0;
            fcnt    <= '0;
        end
    end

endmodule

// File: rtl/i2s_frame_sequencer.sv
// i2s_frame_sequencer: stereo I2S DAC link sequencer.
// Start/stop FSM, one-entry holding buffer, underrun tracking, serializer.
module i2s_frame_sequencer
    import synth_audio_pkg::*;
#(
    parameter int MCLK_HALF = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                s_ready,
    output logic                mclk,
    output logic                sck,
    output logic                lrck,
    output logic                sdout,
    output logic                busy,
    output logic                underrun,
    output logic [7:0]          underrun_cnt
);

    state_t           state;
    pair_t            hold;
    pair_t            shift;
    logic             hold_empty;
    logic [BIT_W-1:0] bit_next;
    logic             wrap;
    logic             sck_fall;
    logic             run;
    logic             entry;
    logic             tick;
    logic             accept;

    assign run     = (state != IDLE);
    assign entry   = (state == IDLE) && en;
    assign tick    = entry || (wrap && ((state == RUN) || en));
    assign accept  = s_valid && hold_empty;
    assign s_ready = hold_empty;

    i2s_clk_gen #(
        .MCLK_HALF(MCLK_HALF)
    ) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mclk     (mclk),
        .sck      (sck),
        .lrck     (lrck),
        .bit_next (bit_next),
        .wrap     (wrap),
        .sck_fall (sck_fall)
    );

    // Run/stop FSM; a stop request lets the current frame finish first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) state <= DRAIN;
                end
                DRAIN: begin
                    if (en) begin
                        state <= RUN;
                    end else if (wrap) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Holding buffer and per-frame load; an empty buffer at a tick is an underrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold         <= '0;
            shift        <= '0;
            hold_empty   <= 1'b1;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= tick && hold_empty;
            if (tick) begin
                shift <= hold_empty ? '0 : hold;
                if (hold_empty && underrun_cnt != 8'hFF) begin
                    underrun_cnt <= underrun_cnt + 8'd1;
                end
            end
            if (accept) begin
                hold       <= '{left: s_left, right: s_right};
                hold_empty <= 1'b0;
            end else if (tick) begin
                hold_empty <= 1'b1;
            end
        end
    end

    // Serializer: new bit at each sck fall so it is stable at sck rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdout <= 1'b0;
        end else if (sck_fall) begin
            sdout <= slot_bit(shift, bit_next);
        end
    end

endmodule

// File: doc/i2s_frame_sequencer.md
Name: i2s_frame_sequencer

Overview:
Sequences the stereo serial DAC link in the synthesiser output path. Derives mclk/sck/lrck from the system clock and pulls one left/right 16-bit sample pair per frame from the voice mixer over a valid/ready handshake. Serializes each pair in I2S format: MSB first, one-sck delay after each lrck edge, 32-bit slots. Handles start/stop sequencing and sample underrun.

Parameters:
MCLK_HALF, 2, clk cycles per mclk half-period (>=1); mclk = clk/(2*MCLK_HALF)
SAMPLE_W, 16, sample width per channel (fixed by package; slot width 32)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  run request; level-sensitive
s_valid  in  1  mixer has a sample pair
s_left  in  16  left sample, two's complement
s_right  in  16  right sample
s_ready  out  1  holding buffer empty; pair accepted when s_valid & s_ready
mclk  out  1  master clock, 256*fs
sck  out  1  bit clock, mclk/4, 64*fs
lrck  out  1  0 = left, 1 = right
sdout  out  1  serial data
busy  out  1  state != IDLE
underrun  out  1  one-clk pulse, frame started with no sample
underrun_cnt  out  8  saturating underrun count

Behaviour:
- Reset (rst=0, async): state IDLE, fcnt=0, div_cnt=0, holding empty. mclk/sck/lrck/sdout/busy/underrun=0, underrun_cnt=0, s_ready=1.
- Prescaler: div_cnt counts 0..MCLK_HALF-1. At terminal count mclk toggles. On each mclk 1->0 toggle, fcnt (8 bit) increments, wrapping 255->0.
- Derived timing: sck = fcnt[1]; lrck = fcnt[7]; bit index b = fcnt[7:2] (0..63); slot s = b[4:0].
- sdout is registered and updates only in the clk where fcnt[1:0] becomes 0 (sck falling edge), so it is stable at sck rising.
  - s in 1..16: sdout = ch[16-s], where ch = left when b<32, right otherwise.
  - Else sdout = 0.
- Frame tick: the clk where fcnt becomes 0, plus the IDLE->RUN entry clk. On a frame tick:
  - Holding full: load the shift pair from holding, mark holding empty.
  - Holding empty: load zeros, pulse underrun, underrun_cnt += 1 (saturate at 255).
- Holding buffer: one entry. s_ready = holding empty (registered).
  - A handshake in the same clk as a frame tick with holding empty counts as underrun for this frame and fills holding for the next frame.
- Latency: accepted pair -> loaded at next frame tick. Left MSB appears on sdout 4 mclk periods (b=1) after the tick.
- FSM:
  - IDLE: clock outputs held 0, counters 0. en=1 -> RUN (entry frame tick).
  - RUN: en=0 -> DRAIN.
  - DRAIN: keep running. en=1 -> RUN, no glitch or restart. fcnt wrap 255->0 -> IDLE; all outputs low; no load and no underrun on that wrap.
- Holding buffer contents survive IDLE, and s_ready still works in IDLE.
- underrun_cnt clears only on reset.

Decomposition:
- Package synth_audio_pkg:
  - SAMPLE_W=16, SLOT_W=32, MCLK_PER_SCK=4, FRAME_MCLK=256.
  - State enum {IDLE, RUN, DRAIN}.
- Sub-module i2s_clk_gen: prescaler, mclk, fcnt, frame-tick strobe and sck-fall strobe.
- FSM, holding buffer and serializer stay in the top of this block.

Test Plan:
- Reset: rst=0 mid-anything -> all outputs 0 immediately, s_ready=1, underrun_cnt=0. Release with en=0 -> outputs stay 0.
- Single pair: MCLK_HALF=1, push L=16'hA5C3, R=16'h0001, then en=1.
  - Frame = 512 clk, 64 sck, lrck low for 32 sck then high for 32 sck.
  - Sampled at sck rising, left slot bits 1..16 = 1010010111000011, all other left bits 0.
  - Right slot bit 16 = 1, all other bits 0.
- Underrun: no sample pushed for frame 2 -> all 64 sdout bits 0, one underrun pulse at the frame tick, underrun_cnt=1. Run 300 empty frames -> underrun_cnt=255.
- Backpressure: s_valid held high with 3 queued pairs -> s_ready drops after the first accept and rises one clk after each frame tick. Exactly one pair is consumed per frame, in order.
- Stop/restart:
  - en=0 at b=10 -> frame completes all 64 bits, then busy=0 and mclk/sck/lrck/sdout=0.
  - en re-asserted during DRAIN -> next frame follows with no gap.
- Async reset at b=20 -> outputs 0 in the same clk, queued pair discarded. After release with en=1, first frame underruns (cnt=1).
